// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and helpers for the MIPS data-port load/store unit.
`default_nettype none

package mips_mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } lsu_state_t;

  function automatic logic is_store(input mem_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (op inside {OP_LH, OP_LHU, OP_SH}) mis = off[0];
    if (op inside {OP_LW, OP_SW})         mis = (off != 2'd0);
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian byte/half lane extraction (loads) and lane merge (stores).
`default_nettype none

module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  mem_op_t     op,
  input  logic [1:0]  off,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    unique case (off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // addr[0] is ignored for halfwords; only meaningful when alignment checks are off
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    extracted = word;
    case (op)
      OP_LB:   extracted = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  extracted = {24'd0, byte_sel};
      OP_LH:   extracted = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  extracted = {16'd0, half_sel};
      default: extracted = word;
    endcase
  end

  always_comb begin
    merged = wdata;
    case (op)
      OP_SB: begin
        merged = word;
        unique case (off)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      OP_SH: begin
        merged = word;
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit: single-outstanding load/store initiator for the word-wide data RAM,
// with sub-word stores done as read-modify-write.
`default_nettype none

module mips_load_store_unit
  import mips_mem_pkg::*;
#(
  parameter bit          CHECK_ALIGN = 1'b1,
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  mem_op_t     req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  lsu_state_t  state, next_state;
  mem_op_t     op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        accept_err;
  logic [31:0] extracted, merged;

  assign accept_err = CHECK_ALIGN && is_misaligned(req_op, req_addr[1:0]);

  lsu_lane_align u_align (
    .word      (data_readdata),
    .wdata     (wdata_q),
    .op        (op_q),
    .off       (off_q),
    .extracted (extracted),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (accept_err)            next_state = DONE;
          else if (!is_store(req_op)) next_state = LOAD;
          else if (req_op == OP_SW)  next_state = WRITE;
          else                       next_state = RMW_RD;
        end
      end
      LOAD:    next_state = DONE;
      RMW_RD:  next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and handshake decode straight from the state register
  assign req_ready  = (state == IDLE);
  assign data_read  = (state == LOAD) || (state == RMW_RD);
  assign data_write = (state == WRITE);
  assign resp_valid = (state == DONE);
  assign resp_error = (state == DONE) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= OP_LB;
      off_q          <= 2'd0;
      wdata_q        <= 32'd0;
      err_q          <= 1'b0;
      resp_rdata     <= 32'd0;
      data_writedata <= 32'd0;
      data_address   <= IDLE_ADDR;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            err_q   <= accept_err;
            if (accept_err) resp_rdata <= 32'd0;
            else            data_address <= {req_addr[31:2], 2'b00};
            if (next_state == WRITE) data_writedata <= req_wdata;
          end
        end
        LOAD: begin
          resp_rdata   <= extracted;
          data_address <= IDLE_ADDR;
        end
        RMW_RD: data_writedata <= merged;
        WRITE: begin
          resp_rdata   <= 32'd0;
          data_address <= IDLE_ADDR;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_load_store_unit.sv
// tb_mips_load_store_unit: scoreboard bench with a word-array RAM and an arithmetic reference model.
`default_nettype none

module tb_mips_load_store_unit;
  import mips_mem_pkg::*;

  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  mem_op_t     req_op = OP_LB;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  always #(PERIOD/2) clk = ~clk;

  mips_load_store_unit #(.CHECK_ALIGN(1'b1), .IDLE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  // RAM: combinational read, write on the rising edge
  logic [31:0] ram [0:8191];
  assign data_readdata = ram[data_address[14:2]];
  always @(posedge clk) if (data_write) ram[data_address[14:2]] <= data_writedata;

  logic [31:0] model_mem [0:8191];

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wword;
    logic [31:0] waddr;
    longint      t_acc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain shift/mask arithmetic on a word array
  task automatic model(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                       inout exp_t e);
    int unsigned off, w, sh, hs, b, h, mask;
    bit mis;
    off = addr % 4;
    w   = model_mem[addr[14:2]];
    sh  = 8 * off;
    hs  = 16 * (off / 2);
    mis = ((op == OP_LH || op == OP_LHU || op == OP_SH) && (off % 2 != 0)) ||
          ((op == OP_LW || op == OP_SW) && off != 0);
    e.rdata = 0; e.err = 0; e.nrd = 0; e.nwr = 0; e.wword = 0;
    e.waddr = addr & 32'hFFFF_FFFC;
    if (mis) begin
      e.err = 1; e.lat = 1;
    end else if (op == OP_SW) begin
      e.lat = 2; e.nwr = 1; e.wword = wd;
      model_mem[addr[14:2]] = wd;
    end else if (op == OP_SB || op == OP_SH) begin
      mask = (op == OP_SB) ? (32'hFF << sh) : (32'hFFFF << hs);
      e.wword = (w & ~mask) | ((op == OP_SB) ? ((wd & 32'hFF) << sh) : ((wd & 32'hFFFF) << hs));
      e.lat = 3; e.nrd = 1; e.nwr = 1;
      model_mem[addr[14:2]] = e.wword;
    end else begin
      e.lat = 2; e.nrd = 1;
      b = (w >> sh) & 32'hFF;
      h = (w >> hs) & 32'hFFFF;
      case (op)
        OP_LB:   e.rdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
        OP_LBU:  e.rdata = b;
        OP_LH:   e.rdata = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
        OP_LHU:  e.rdata = h;
        default: e.rdata = w;
      endcase
    end
  endtask

  task automatic do_req(input string nm, input mem_op_t op, input logic [31:0] addr,
                        input logic [31:0] wd, input bit use_k = 0, input logic [31:0] k = 0);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL %s ready_timeout: got 0 expected 1", nm);
      return;
    end
    e.name = nm;
    model(op, addr, wd, e);
    if (use_k) e.rdata = k;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    e.t_acc = $time;
    sbq.push_back(e);
    #1;
    req_valid = 1'b0;
    req_op    = mem_op_t'(3'($urandom_range(0, 7)));
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Monitor: counts strobes per transaction and scores each response
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0; wr_cnt = 0;
    end else begin
      if (data_read && data_write) begin
        checks++; errors++;
        $display("FAIL strobe_overlap: got read=1 write=1 expected not both");
      end
      if ((data_read || data_write) && sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL stray_strobe: got read=%0b write=%0b expected idle bus", data_read, data_write);
      end else begin
        if (data_read) begin
          rd_cnt++;
          chk({sbq[0].name, " rd_addr"}, data_address, sbq[0].waddr);
        end
        if (data_write) begin
          wr_cnt++;
          chk({sbq[0].name, " wr_addr"}, data_address, sbq[0].waddr);
          chk({sbq[0].name, " wr_data"}, data_writedata, sbq[0].wword);
        end
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk({e.name, " rdata"}, resp_rdata, e.rdata);
          chk({e.name, " error"}, 32'(resp_error), 32'(e.err));
          chk({e.name, " latency"}, 32'(($time - e.t_acc + PERIOD/2) / PERIOD), 32'(e.lat));
          chk({e.name, " nread"}, 32'(rd_cnt), 32'(e.nrd));
          chk({e.name, " nwrite"}, 32'(wr_cnt), 32'(e.nwr));
          chk({e.name, " addr_idle"}, data_address, 32'h0);
        end
        rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  initial begin
    #(200000 * PERIOD);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_word;
    int n;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_error", 32'(resp_error), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst strobes", {30'd0, data_read, data_write}, 32'd0);
    chk("rst writedata", data_writedata, 32'd0);
    chk("rst address", data_address, 32'h0);
    #(3 * PERIOD);
    @(negedge clk) rst_n = 1'b1;

    do_req("pre_sw",  OP_SW,  32'h8000_0010, 32'hAABB_CCDD);
    do_req("lb",      OP_LB,  32'h8000_0013, 32'h0, 1, 32'hFFFF_FFAA);
    do_req("lbu",     OP_LBU, 32'h8000_0013, 32'h0, 1, 32'h0000_00AA);
    do_req("lh",      OP_LH,  32'h8000_0010, 32'h0, 1, 32'hFFFF_CCDD);
    do_req("lhu",     OP_LHU, 32'h8000_0012, 32'h0, 1, 32'h0000_AABB);
    do_req("lw",      OP_LW,  32'h8000_0010, 32'h0, 1, 32'hAABB_CCDD);
    do_req("sb",      OP_SB,  32'h8000_0011, 32'h1234_5677);
    do_req("lw_sb",   OP_LW,  32'h8000_0010, 32'h0, 1, 32'hAABB_77DD);
    do_req("pre_sw2", OP_SW,  32'hBFC0_0000, 32'h1122_3344);
    do_req("sh",      OP_SH,  32'hBFC0_0002, 32'h0000_BEEF);
    do_req("lw_sh",   OP_LW,  32'hBFC0_0000, 32'h0, 1, 32'hBEEF_3344);
    do_req("sw",      OP_SW,  32'hBFC0_0000, 32'hCAFE_F00D);
    do_req("lw_sw",   OP_LW,  32'hBFC0_0000, 32'h0, 1, 32'hCAFE_F00D);
    do_req("lw_mis",  OP_LW,  32'h8000_0002, 32'h0);
    do_req("lh_mis",  OP_LH,  32'h8000_0011, 32'h0);
    do_req("sh_mis",  OP_SH,  32'h8000_0013, 32'hFFFF);
    do_req("sw_mis",  OP_SW,  32'h8000_0011, 32'hFFFF_FFFF);
    do_req("lw_after_mis", OP_LW, 32'h8000_0010, 32'h0, 1, 32'hAABB_77DD);

    for (int i = 0; i < 16; i++)
      do_req("init_sw", OP_SW, 32'h8000_0100 + 32'(i * 4), $urandom);
    for (int i = 0; i < 80; i++)
      do_req("rand", mem_op_t'(3'($urandom_range(0, 7))),
             32'h8000_0100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3)),
             $urandom);

    // Reset during the read half of an SB read-modify-write
    n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    old_word = model_mem[13'h40];
    do_req("sb_rst", OP_SB, 32'h8000_0101, 32'h0000_005A);
    #2;
    chk("rst_mid read_before", 32'(data_read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid read_drop", 32'(data_read), 32'd0);
    chk("rst_mid write", 32'(data_write), 32'd0);
    chk("rst_mid resp", 32'(resp_valid), 32'd0);
    sbq.delete();
    model_mem[13'h40] = old_word;
    #(2 * PERIOD);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_mid ready_after", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("rst_mid ram_unchanged", ram[13'h40], old_word);
    do_req("lw_rst", OP_LW, 32'h8000_0100, 32'h0);

    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
